// File: rtl/if_prefetch_queue.sv
// Instruction prefetch queue: issues word fetches ahead of the decoder, buffers
// responses with their pc+4, and flushes/re-targets on a redirect.
module if_prefetch_queue #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0,
    localparam int unsigned CW      = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          redirect,
    input  logic [31:0]   redirect_pc,
    output logic          mem_req,
    output logic [31:0]   mem_addr,
    input  logic          mem_gnt,
    input  logic          mem_rvalid,
    input  logic [31:0]   mem_rdata,
    output logic          out_valid,
    output logic [31:0]   out_instr,
    output logic [31:0]   out_pc4,
    input  logic          out_ready,
    output logic [CW-1:0] dbg_count,
    output logic [CW-1:0] dbg_in_flight,
    output logic [CW-1:0] dbg_drop_cnt
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic [31:0]   resp_pc_q, resp_pc_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [CW-1:0] in_flight_q, in_flight_d;
    logic [CW-1:0] drop_cnt_q, drop_cnt_d;

    logic [31:0]   instr_mem_q [DEPTH];
    logic [31:0]   pc4_mem_q   [DEPTH];

    logic [CW-1:0] live;
    logic [CW:0]   credit_used;
    logic          rsp_ok;
    logic          transfer;
    logic          push;
    logic          pop;

    // Handshakes: a request transfers when mem_req && mem_gnt; the head is
    // consumed when out_valid && out_ready. A redirect cycle masks both the
    // request and the pop, and any response arriving in it is discarded.
    always_comb begin
        live        = in_flight_q - drop_cnt_q;
        credit_used = {1'b0, count_q} + {1'b0, live};
        mem_req     = (credit_used < (CW + 1)'(DEPTH)) && (in_flight_q < CW'(DEPTH)) && !redirect;
        mem_addr    = fetch_pc_q;
        rsp_ok      = mem_rvalid && (in_flight_q != '0);
        transfer    = mem_req && mem_gnt;
        push        = rsp_ok && (drop_cnt_q == '0) && !redirect;
        out_valid   = (count_q != '0);
        pop         = out_valid && out_ready && !redirect;
        out_instr   = out_valid ? instr_mem_q[rd_ptr_q] : 32'h0;
        out_pc4     = out_valid ? pc4_mem_q[rd_ptr_q] : 32'h0;
    end

    always_comb begin
        fetch_pc_d  = fetch_pc_q;
        resp_pc_d   = resp_pc_q;
        rd_ptr_d    = rd_ptr_q;
        wr_ptr_d    = wr_ptr_q;
        count_d     = count_q;
        in_flight_d = in_flight_q;
        drop_cnt_d  = drop_cnt_q;

        if (transfer && !rsp_ok) begin
            in_flight_d = in_flight_q + CW'(1);
        end else if (!transfer && rsp_ok) begin
            in_flight_d = in_flight_q - CW'(1);
        end

        if (transfer) begin
            fetch_pc_d = fetch_pc_q + 32'd4;
        end

        if (redirect) begin
            // Every fetch still outstanding after this cycle belongs to the old path.
            fetch_pc_d = {redirect_pc[31:2], 2'b00};
            resp_pc_d  = {redirect_pc[31:2], 2'b00};
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
            count_d    = '0;
            drop_cnt_d = in_flight_q - (rsp_ok ? CW'(1) : CW'(0));
        end else begin
            if (rsp_ok && (drop_cnt_q != '0)) begin
                drop_cnt_d = drop_cnt_q - CW'(1);
            end
            if (push) begin
                wr_ptr_d  = wr_ptr_q + AW'(1);
                resp_pc_d = resp_pc_q + 32'd4;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            case ({push, pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_pc_q  <= RESET_PC;
            resp_pc_q   <= RESET_PC;
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            count_q     <= '0;
            in_flight_q <= '0;
            drop_cnt_q  <= '0;
        end else begin
            fetch_pc_q  <= fetch_pc_d;
            resp_pc_q   <= resp_pc_d;
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            count_q     <= count_d;
            in_flight_q <= in_flight_d;
            drop_cnt_q  <= drop_cnt_d;
        end
    end

    // Entry storage needs no reset: outputs are gated by count.
    always_ff @(posedge clk) begin
        if (!reset && push) begin
            instr_mem_q[wr_ptr_q] <= mem_rdata;
            pc4_mem_q[wr_ptr_q]   <= resp_pc_q + 32'd4;
        end
    end

    assign dbg_count     = count_q;
    assign dbg_in_flight = in_flight_q;
    assign dbg_drop_cnt  = drop_cnt_q;

endmodule

// File: tb/tb_if_prefetch_queue.sv
// Bench for if_prefetch_queue: a memory model plus an epoch-tagged scoreboard
// of which fetched words must reach the consumer, and in what order.
module tb_if_prefetch_queue;

    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0;

    logic        clk = 1'b0;
    logic        reset;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic        out_valid;
    logic [31:0] out_instr;
    logic [31:0] out_pc4;
    logic        out_ready;
    logic [2:0]  dbg_count;
    logic [2:0]  dbg_in_flight;
    logic [2:0]  dbg_drop_cnt;

    if_prefetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
        .clk(clk), .reset(reset), .redirect(redirect), .redirect_pc(redirect_pc),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_gnt(mem_gnt),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .out_valid(out_valid), .out_instr(out_instr), .out_pc4(out_pc4),
        .out_ready(out_ready), .dbg_count(dbg_count),
        .dbg_in_flight(dbg_in_flight), .dbg_drop_cnt(dbg_drop_cnt)
    );

    always #5 clk = ~clk;

    // Scoreboard: words the consumer must see, as {instr, pc4}.
    logic [63:0] exp_q[$];
    // Memory model: outstanding requests with path epoch and earliest response edge.
    logic [31:0] mq_addr[$];
    int          mq_ep[$];
    int          mq_rdy[$];
    logic [31:0] gnt_log[$];
    logic [63:0] pop_log[$];
    logic [31:0] exp_fetch;
    logic [31:0] salt;
    int          cur_ep, cyc, lat, xfer_cnt;
    int          n_checks, n_errors;
    bit          rsp_stall_rand;

    function automatic logic [31:0] mem_data(input logic [31:0] a);
        return a ^ salt;
    endfunction

    task automatic drive_mem();
        if (mq_addr.size() > 0 && mq_rdy[0] <= cyc + 1 &&
            !(rsp_stall_rand && $urandom_range(0, 3) == 0)) begin
            mem_rvalid = 1'b1;
            mem_rdata  = mem_data(mq_addr[0]);
        end else begin
            mem_rvalid = 1'b0;
            mem_rdata  = $urandom;
        end
    endtask

    task automatic tick();
        int          live;
        logic        exp_req;
        logic [63:0] head;
        #1;
        if (!reset) begin
            live = 0;
            foreach (mq_ep[i]) if (mq_ep[i] == cur_ep) live++;
            exp_req = (exp_q.size() + live < DEPTH) && (mq_addr.size() < DEPTH) && !redirect;
            head = (exp_q.size() > 0) ? exp_q[0] : 64'h0;
            n_checks++;
            if (out_valid !== (exp_q.size() > 0)) begin
                n_errors++;
                $display("FAIL out_valid cyc=%0d got %b exp %b", cyc, out_valid, exp_q.size() > 0);
            end
            n_checks++;
            if ({out_instr, out_pc4} !== head) begin
                n_errors++;
                $display("FAIL head cyc=%0d got %h exp %h", cyc, {out_instr, out_pc4}, head);
            end
            n_checks++;
            if (mem_req !== exp_req) begin
                n_errors++;
                $display("FAIL mem_req cyc=%0d got %b exp %b", cyc, mem_req, exp_req);
            end
            if (exp_req) begin
                n_checks++;
                if (mem_addr !== exp_fetch) begin
                    n_errors++;
                    $display("FAIL mem_addr cyc=%0d got %h exp %h", cyc, mem_addr, exp_fetch);
                end
            end
            n_checks++;
            if (dbg_in_flight !== 3'(mq_addr.size())) begin
                n_errors++;
                $display("FAIL in_flight cyc=%0d got %0d exp %0d", cyc, dbg_in_flight, mq_addr.size());
            end
            n_checks++;
            if (dbg_drop_cnt !== 3'(mq_addr.size() - live)) begin
                n_errors++;
                $display("FAIL drop_cnt cyc=%0d got %0d exp %0d", cyc, dbg_drop_cnt, mq_addr.size() - live);
            end
            n_checks++;
            if (dbg_count !== 3'(exp_q.size())) begin
                n_errors++;
                $display("FAIL count cyc=%0d got %0d exp %0d", cyc, dbg_count, exp_q.size());
            end
            if (mem_req && mem_gnt) begin
                gnt_log.push_back(mem_addr);
                xfer_cnt++;
            end
            if (out_valid && out_ready && !redirect) pop_log.push_back({out_instr, out_pc4});
            if (exp_q.size() > 0 && out_ready && !redirect) void'(exp_q.pop_front());
            if (mem_rvalid && mq_addr.size() > 0) begin
                if (mq_ep[0] == cur_ep && !redirect)
                    exp_q.push_back({mem_data(mq_addr[0]), mq_addr[0] + 32'd4});
                void'(mq_addr.pop_front());
                void'(mq_ep.pop_front());
                void'(mq_rdy.pop_front());
            end
            if (exp_req && mem_gnt) begin
                mq_addr.push_back(exp_fetch);
                mq_ep.push_back(cur_ep);
                mq_rdy.push_back(cyc + 1 + lat);
                exp_fetch = exp_fetch + 32'd4;
            end
            if (redirect) begin
                cur_ep++;
                exp_fetch = {redirect_pc[31:2], 2'b00};
                exp_q.delete();
            end
        end else begin
            exp_q.delete();
            mq_addr.delete();
            mq_ep.delete();
            mq_rdy.delete();
            cur_ep++;
            exp_fetch = RESET_PC;
        end
        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    task automatic cyc_drive(input logic gnt, input logic rdy);
        mem_gnt   = gnt;
        out_ready = rdy;
        redirect  = 1'b0;
        drive_mem();
        tick();
    endtask

    task automatic apply_reset();
        reset       = 1'b1;
        redirect    = 1'b0;
        redirect_pc = $urandom;
        mem_rvalid  = 1'b0;
        mem_rdata   = $urandom;
        mem_gnt     = 1'($urandom_range(0, 1));
        out_ready   = 1'($urandom_range(0, 1));
        repeat (2) tick();
        reset = 1'b0;
        gnt_log.delete();
        pop_log.delete();
        xfer_cnt = 0;
    endtask

    task automatic test_reset();
        lat = 1; salt = 32'h0; rsp_stall_rand = 0;
        apply_reset();
        redirect = 1'b0; mem_gnt = 1'b0; out_ready = 1'b1;
        mem_rvalid = 1'b1; mem_rdata = 32'hDEADBEEF;
        #1;
        n_checks++;
        if (out_valid !== 1'b0 || out_instr !== 32'h0 || out_pc4 !== 32'h0) begin
            n_errors++;
            $display("FAIL reset_out got %b %h %h exp 0 0 0", out_valid, out_instr, out_pc4);
        end
        n_checks++;
        if (mem_req !== 1'b1 || mem_addr !== RESET_PC) begin
            n_errors++;
            $display("FAIL reset_req got %b %h exp 1 %h", mem_req, mem_addr, RESET_PC);
        end
        tick();
        mem_rvalid = 1'b0;
        #1;
        n_checks++;
        if (out_valid !== 1'b0 || dbg_in_flight !== 3'd0) begin
            n_errors++;
            $display("FAIL spurious_rvalid got valid=%b in_flight=%0d exp 0 0", out_valid, dbg_in_flight);
        end
        repeat (3) cyc_drive(1'b1, 1'b1);
    endtask

    task automatic test_stream();
        lat = 1; salt = 32'h0;
        apply_reset();
        for (int k = 1; k <= 14; k++) begin
            mem_gnt = 1'b1; out_ready = 1'b1; redirect = 1'b0;
            drive_mem();
            #1;
            n_checks++;
            if (out_valid !== (k >= 3)) begin
                n_errors++;
                $display("FAIL stream_valid k=%0d got %b exp %b", k, out_valid, k >= 3);
            end
            if (k >= 3) begin
                n_checks++;
                if (out_instr !== 32'(4 * (k - 3)) || out_pc4 !== 32'(4 * (k - 2))) begin
                    n_errors++;
                    $display("FAIL stream_data k=%0d got %h/%h exp %h/%h", k, out_instr, out_pc4,
                             32'(4 * (k - 3)), 32'(4 * (k - 2)));
                end
            end
            tick();
        end
    endtask

    task automatic test_backpressure();
        lat = 1; salt = $urandom;
        apply_reset();
        repeat (10) cyc_drive(1'b1, 1'b0);
        mem_gnt = 1'b1; out_ready = 1'b0; redirect = 1'b0;
        drive_mem();
        #1;
        n_checks++;
        if (xfer_cnt != 4 || mem_req !== 1'b0 || dbg_count !== 3'd4) begin
            n_errors++;
            $display("FAIL backpressure got xfers=%0d req=%b count=%0d exp 4 0 4", xfer_cnt, mem_req, dbg_count);
        end
        pop_log.delete();
        repeat (8) cyc_drive(1'b1, 1'b1);
        n_checks++;
        if (pop_log.size() < 4) begin
            n_errors++;
            $display("FAIL drain_count got %0d exp >=4", pop_log.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                n_checks++;
                if (pop_log[i] !== {mem_data(32'(4 * i)), 32'(4 * i + 4)}) begin
                    n_errors++;
                    $display("FAIL drain_order i=%0d got %h exp %h", i, pop_log[i],
                             {mem_data(32'(4 * i)), 32'(4 * i + 4)});
                end
            end
        end
    endtask

    task automatic test_redirect_drop();
        lat = 3; salt = $urandom;
        apply_reset();
        repeat (3) cyc_drive(1'b1, 1'b1);
        mem_gnt = 1'b1; out_ready = 1'b1; redirect = 1'b1; redirect_pc = 32'h100;
        drive_mem();
        #1;
        n_checks++;
        if (dbg_in_flight !== 3'd3) begin
            n_errors++;
            $display("FAIL drop_setup got in_flight=%0d exp 3", dbg_in_flight);
        end
        tick();
        redirect = 1'b0;
        gnt_log.delete();
        pop_log.delete();
        drive_mem();
        #1;
        n_checks++;
        if (dbg_drop_cnt !== 3'd2) begin
            n_errors++;
            $display("FAIL drop_cnt_after got %0d exp 2", dbg_drop_cnt);
        end
        for (int i = 0; i < 30 && pop_log.size() == 0; i++) cyc_drive(1'b1, 1'b1);
        n_checks++;
        if (pop_log.size() == 0) begin
            n_errors++;
            $display("FAIL drop_timeout got 0 pops exp >=1");
        end else if (pop_log[0] !== {mem_data(32'h100), 32'h104}) begin
            n_errors++;
            $display("FAIL drop_first got %h exp %h", pop_log[0], {mem_data(32'h100), 32'h104});
        end
        n_checks++;
        if (gnt_log.size() == 0 || gnt_log[0] !== 32'h100) begin
            n_errors++;
            $display("FAIL drop_target got %h exp 00000100", gnt_log.size() ? gnt_log[0] : 32'hx);
        end
    endtask

    task automatic test_wrap();
        logic [31:0] ea[3];
        logic [31:0] ep[3];
        ea[0] = 32'hFFFF_FFF8; ea[1] = 32'hFFFF_FFFC; ea[2] = 32'h0;
        ep[0] = 32'hFFFF_FFFC; ep[1] = 32'h0;         ep[2] = 32'h4;
        lat = 1; salt = $urandom;
        apply_reset();
        repeat (3) cyc_drive(1'b1, 1'b1);
        mem_gnt = 1'b1; out_ready = 1'b1; redirect = 1'b1; redirect_pc = 32'hFFFF_FFFB;
        drive_mem();
        tick();
        redirect = 1'b0;
        gnt_log.delete();
        pop_log.delete();
        drive_mem();
        #1;
        n_checks++;
        if (mem_req !== 1'b1 || mem_addr !== 32'hFFFF_FFF8) begin
            n_errors++;
            $display("FAIL wrap_first got %b %h exp 1 fffffff8", mem_req, mem_addr);
        end
        repeat (8) cyc_drive(1'b1, 1'b1);
        n_checks++;
        if (gnt_log.size() < 3 || pop_log.size() < 3) begin
            n_errors++;
            $display("FAIL wrap_count got %0d/%0d exp >=3", gnt_log.size(), pop_log.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                n_checks++;
                if (gnt_log[i] !== ea[i] || pop_log[i][31:0] !== ep[i]) begin
                    n_errors++;
                    $display("FAIL wrap i=%0d got %h/%h exp %h/%h", i, gnt_log[i], pop_log[i][31:0], ea[i], ep[i]);
                end
            end
        end
    endtask

    task automatic test_redirect_collide();
        bit          hit;
        int          infl;
        logic        rv;
        lat = 2; salt = $urandom; hit = 0;
        apply_reset();
        for (int i = 0; i < 20 && !hit; i++) begin
            mem_gnt = 1'b1; out_ready = 1'b1; redirect = 1'b0;
            drive_mem();
            if (mem_rvalid && exp_q.size() > 0) begin
                hit = 1; redirect = 1'b1; redirect_pc = 32'h200;
            end
            tick();
        end
        n_checks++;
        if (!hit) begin
            n_errors++;
            $display("FAIL collide_setup got no rvalid+pop cycle exp one");
        end
        mem_gnt = 1'b1; out_ready = 1'b1; redirect = 1'b1; redirect_pc = 32'h300;
        drive_mem();
        infl = mq_addr.size();
        rv = mem_rvalid;
        tick();
        redirect = 1'b0;
        pop_log.delete();
        drive_mem();
        #1;
        n_checks++;
        if (dbg_drop_cnt !== 3'(infl - (rv ? 1 : 0))) begin
            n_errors++;
            $display("FAIL collide_drop got %0d exp %0d", dbg_drop_cnt, infl - (rv ? 1 : 0));
        end
        repeat (20) cyc_drive(1'b1, 1'b1);
        n_checks++;
        if (pop_log.size() == 0) begin
            n_errors++;
            $display("FAIL collide_timeout got 0 pops exp >=1");
        end else begin
            for (int i = 0; i < pop_log.size(); i++) begin
                n_checks++;
                if (pop_log[i][31:0] !== 32'h304 + 32'(4 * i)) begin
                    n_errors++;
                    $display("FAIL collide_pc4 i=%0d got %h exp %h", i, pop_log[i][31:0], 32'h304 + 32'(4 * i));
                end
            end
        end
    endtask

    task automatic test_reset_midstream();
        lat = 3; salt = $urandom;
        apply_reset();
        repeat (5) cyc_drive(1'b1, 1'b0);
        reset = 1'b1; redirect = 1'b1; redirect_pc = 32'h500;
        mem_gnt = 1'b1; out_ready = 1'b1; mem_rvalid = 1'b0;
        tick();
        reset = 1'b0; redirect = 1'b0;
        drive_mem();
        #1;
        n_checks++;
        if (out_valid !== 1'b0 || dbg_in_flight !== 3'd0 || mem_req !== 1'b1 || mem_addr !== RESET_PC) begin
            n_errors++;
            $display("FAIL midreset got v=%b inf=%0d req=%b addr=%h exp 0 0 1 %h",
                     out_valid, dbg_in_flight, mem_req, mem_addr, RESET_PC);
        end
        repeat (10) cyc_drive(1'b1, 1'b1);
    endtask

    task automatic test_random();
        for (int it = 0; it < 4; it++) begin
            lat = $urandom_range(1, 4); salt = $urandom; rsp_stall_rand = 1;
            apply_reset();
            for (int c = 0; c < 400; c++) begin
                mem_gnt   = ($urandom_range(0, 3) != 0);
                out_ready = ($urandom_range(0, 9) < 7);
                redirect  = ($urandom_range(0, 29) == 0);
                redirect_pc = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                                          : $urandom;
                drive_mem();
                tick();
            end
            rsp_stall_rand = 0;
        end
    endtask

    initial begin
        n_checks = 0; n_errors = 0; cyc = 0; cur_ep = 0; xfer_cnt = 0;
        lat = 1; salt = 32'h0; rsp_stall_rand = 0; exp_fetch = RESET_PC;
        reset = 1'b1; redirect = 1'b0; redirect_pc = 32'h0; mem_gnt = 1'b0;
        mem_rvalid = 1'b0; mem_rdata = 32'h0; out_ready = 1'b0;
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect_drop();
        test_wrap();
        test_redirect_collide();
        test_reset_midstream();
        test_random();
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog got timeout exp finish");
        $fatal(1, "watchdog");
    end

endmodule
